// File: rtl/ccl_window_gen_pkg.sv
// Shared widths and types for the CCL window generator slice.
// Optional frame-sync feature is selected with CCL_FRAME_SYNC_EN (see ccl_window_gen).
package ccl_window_gen_pkg;

    localparam int CCL_WORD_SIZE  = 8;
    localparam int CCL_IMG_WIDTH  = 640;
    localparam int CCL_IMG_HEIGHT = 480;

    typedef logic [CCL_WORD_SIZE-1:0] ccl_label_t;

    // Previous-row neighbours of the current pixel: A (x-1), B (x), C (x+1).
    typedef struct packed {
        ccl_label_t a;
        ccl_label_t b;
        ccl_label_t c;
    } ccl_upper_win_t;

endpackage

// File: rtl/ccl_window_gen_line_buffer.sv
// Single previous-row label store: one synchronous write port, two asynchronous read ports.
module ccl_line_buffer
    import ccl_window_gen_pkg::*;
#(
    parameter int DEPTH = CCL_IMG_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  ccl_label_t    i_wr_data,
    input  logic [AW-1:0] i_rd0_addr,
    output ccl_label_t    o_rd0_data,
    input  logic [AW-1:0] i_rd1_addr,
    output ccl_label_t    o_rd1_data
);

    ccl_label_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd0_data = r_mem[i_rd0_addr];
    assign o_rd1_data = r_mem[i_rd1_addr];

endmodule

// File: rtl/ccl_window_gen.sv
// Causal 3+1 neighbour window and raster counters feeding the CCL labeller.
// Define CCL_FRAME_SYNC_EN to add the sof input (forces the flagged pixel to 0,0).
module ccl_window_gen
    import ccl_window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = CCL_IMG_WIDTH,
    parameter int IMG_HEIGHT = CCL_IMG_HEIGHT,
    parameter int XY_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en_in,
`ifdef CCL_FRAME_SYNC_EN
    input  logic                sof,
`endif
    input  ccl_label_t          pixel_in,
    input  ccl_label_t          label_in,
    output logic                en,
    output ccl_label_t          A,
    output ccl_label_t          B,
    output ccl_label_t          C,
    output ccl_label_t          D,
    output ccl_label_t          p,
    output logic [XY_WIDTH-1:0] x,
    output logic [XY_WIDTH-1:0] y,
    output logic                frame_done
);

    localparam int                AW     = $clog2(IMG_WIDTH);
    localparam logic [XY_WIDTH-1:0] X_LAST = XY_WIDTH'(IMG_WIDTH - 1);
    localparam logic [XY_WIDTH-1:0] Y_LAST = XY_WIDTH'(IMG_HEIGHT - 1);

    logic [XY_WIDTH-1:0] r_x_cnt;
    logic [XY_WIDTH-1:0] r_y_cnt;
    logic                r_en;
    ccl_label_t          r_p;
    logic [XY_WIDTH-1:0] r_x;
    logic [XY_WIDTH-1:0] r_y;
    logic                r_frame_done;
    ccl_upper_win_t      r_abc;
    logic                r_label_vld;
    logic [AW-1:0]       r_x_wr;
    ccl_label_t          r_d_hold;

    logic                w_sof;
    logic [XY_WIDTH-1:0] w_xn;
    logic [XY_WIDTH-1:0] w_yn;
    logic                w_x_last;
    logic                w_y_last;
    logic [AW-1:0]       w_rd0_addr;
    logic [AW-1:0]       w_rd1_addr;
    ccl_label_t          w_rd0_data;
    ccl_label_t          w_rd1_data;

`ifdef CCL_FRAME_SYNC_EN
    assign w_sof = en_in & sof;
`else
    assign w_sof = 1'b0;
`endif

    always_comb begin
        w_xn       = w_sof ? '0 : r_x_cnt;
        w_yn       = w_sof ? '0 : r_y_cnt;
        w_x_last   = (w_xn == X_LAST);
        w_y_last   = (w_yn == Y_LAST);
        w_rd0_addr = AW'(w_xn);
        // x+1 is never read on the last column; keep the address in range.
        w_rd1_addr = w_x_last ? '0 : AW'(w_xn + XY_WIDTH'(1));
    end

    ccl_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .AW    (AW)
    ) u_line_buffer (
        .i_clk      (clk),
        .i_wr_en    (r_label_vld),
        .i_wr_addr  (r_x_wr),
        .i_wr_data  (label_in),
        .i_rd0_addr (w_rd0_addr),
        .o_rd0_data (w_rd0_data),
        .i_rd1_addr (w_rd1_addr),
        .o_rd1_data (w_rd1_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x_cnt      <= '0;
            r_y_cnt      <= '0;
            r_en         <= 1'b0;
            r_p          <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
            r_abc        <= '0;
            r_label_vld  <= 1'b0;
            r_x_wr       <= '0;
            r_d_hold     <= '0;
        end else begin
            r_en         <= en_in;
            r_frame_done <= 1'b0;
            r_label_vld  <= r_en;
            if (r_en) begin
                r_x_wr <= AW'(r_x);
            end
            if (r_label_vld) begin
                r_d_hold <= label_in;
            end
            if (en_in) begin
                r_p          <= pixel_in;
                r_x          <= w_xn;
                r_y          <= w_yn;
                r_frame_done <= w_x_last && w_y_last;
                if (w_x_last) begin
                    r_x_cnt <= '0;
                    r_y_cnt <= w_y_last ? '0 : w_yn + XY_WIDTH'(1);
                end else begin
                    r_x_cnt <= w_xn + XY_WIDTH'(1);
                    r_y_cnt <= w_yn;
                end
                // Row 0 sees no previous row; within a row the window slides left.
                if (w_yn == '0) begin
                    r_abc <= '0;
                end else if (w_xn == '0) begin
                    r_abc.a <= '0;
                    r_abc.b <= w_rd0_data;
                    r_abc.c <= w_rd1_data;
                end else begin
                    r_abc.a <= r_abc.b;
                    r_abc.b <= r_abc.c;
                    r_abc.c <= w_x_last ? '0 : w_rd1_data;
                end
            end
        end
    end

    assign en         = r_en;
    assign p          = r_p;
    assign x          = r_x;
    assign y          = r_y;
    assign frame_done = r_frame_done;
    assign A          = r_abc.a;
    assign B          = r_abc.b;
    assign C          = r_abc.c;
    // Bypass the label of x-1 straight from the labeller so back-to-back pixels see it.
    assign D          = (r_x == '0) ? '0 : (r_label_vld ? label_in : r_d_hold);

endmodule

// File: tb/tb_ccl_window_gen.sv
// Scoreboard bench for ccl_window_gen at W=4, H=3; labeller feedback is emulated.
// Build with CCL_FRAME_SYNC_EN to also exercise the sof input.
module tb_ccl_window_gen;
    import ccl_window_gen_pkg::*;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int XYW = 32;

    typedef struct {
        int         x;
        int         y;
        ccl_label_t a;
        ccl_label_t b;
        ccl_label_t c;
        ccl_label_t d;
        ccl_label_t p;
        logic       fd;
    } exp_t;

    logic            clk;
    logic            reset_n;
    logic            en_in;
`ifdef CCL_FRAME_SYNC_EN
    logic            sof;
`endif
    ccl_label_t      pixel_in;
    ccl_label_t      label_in;
    logic            en;
    ccl_label_t      A, B, C, D, p;
    logic [XYW-1:0]  x, y;
    logic            frame_done;

    exp_t       sb[$];
    ccl_label_t lq[$];
    int         checks = 0;
    int         errors = 0;
    int         m_x = 0;
    int         m_y = 0;
    ccl_label_t m_prev[W];
    ccl_label_t m_cur[W];
    bit         pend = 1'b0;

    ccl_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .XY_WIDTH   (XYW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_in      (en_in),
`ifdef CCL_FRAME_SYNC_EN
        .sof        (sof),
`endif
        .pixel_in   (pixel_in),
        .label_in   (label_in),
        .en         (en),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .p          (p),
        .x          (x),
        .y          (y),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares every presented window against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_en", 32'(en), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("x", x, 32'(e.x));
                    chk("y", y, 32'(e.y));
                    chk("A", 32'(A), 32'(e.a));
                    chk("B", 32'(B), 32'(e.b));
                    chk("C", 32'(C), 32'(e.c));
                    chk("D", 32'(D), 32'(e.d));
                    chk("p", 32'(p), 32'(e.p));
                    chk("frame_done", 32'(frame_done), 32'(e.fd));
                end
            end else begin
                chk("frame_done_idle", 32'(frame_done), 32'd0);
            end
        end
    end

    // Labeller emulation: label for the window of one cycle appears the next cycle.
    always @(negedge clk) pend = reset_n && en;
    always @(posedge clk) begin
        #1;
        if (pend && lq.size() > 0) label_in = lq.pop_front();
        else                       label_in = 8'hEE;
    end

    task automatic send(input ccl_label_t pix, input ccl_label_t lbl, input bit s);
        exp_t e;
        int   xn;
        int   yn;
        xn   = s ? 0 : m_x;
        yn   = s ? 0 : m_y;
        e.x  = xn;
        e.y  = yn;
        e.p  = pix;
        e.a  = '0;
        e.b  = '0;
        e.c  = '0;
        e.d  = '0;
        if (yn != 0) begin
            if (xn != 0)     e.a = m_prev[xn-1];
            e.b = m_prev[xn];
            if (xn != W - 1) e.c = m_prev[xn+1];
        end
        if (xn != 0) e.d = m_cur[xn-1];
        e.fd = (xn == W - 1) && (yn == H - 1);
        sb.push_back(e);
        lq.push_back(lbl);
        m_cur[xn] = lbl;
        if (xn == W - 1) begin
            m_prev = m_cur;
            m_x    = 0;
            m_y    = (yn == H - 1) ? 0 : yn + 1;
        end else begin
            m_x = xn + 1;
            m_y = yn;
        end
        en_in    = 1'b1;
        pixel_in = pix;
`ifdef CCL_FRAME_SYNC_EN
        sof      = s;
`endif
        @(posedge clk);
        #1;
        en_in = 1'b0;
`ifdef CCL_FRAME_SYNC_EN
        sof   = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        en_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_A", 32'(A), 32'd0);
        chk("rst_B", 32'(B), 32'd0);
        chk("rst_C", 32'(C), 32'd0);
        chk("rst_D", 32'(D), 32'd0);
        chk("rst_p", 32'(p), 32'd0);
        chk("rst_x", x, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        #2;
        check_reset_outputs();
        sb.delete();
        lq.delete();
        m_x = 0;
        m_y = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        ccl_label_t f2[12];
        int         guard;
        f2 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd12, 8'd13, 8'd14, 8'd15, 8'd20, 8'd21, 8'd22, 8'd23};
        reset_n  = 1'b0;
        en_in    = 1'b0;
        pixel_in = '0;
        label_in = '0;
`ifdef CCL_FRAME_SYNC_EN
        sof      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset_n = 1'b1;
        idle(2);

        // Frame 1: row 0 labelled 5, row 1 with a 3-cycle gap after x=1.
        for (int i = 0; i < W; i++) send(8'd1, 8'd5, 1'b0);
        send(8'd1, 8'd6, 1'b0);
        send(8'd0, 8'd6, 1'b0);
        idle(3);
        send(8'd1, 8'd7, 1'b0);
        send(8'd1, 8'd7, 1'b0);
        for (int i = 0; i < W; i++) send(8'd1, ccl_label_t'(8 + i), 1'b0);

        // Frame 2: 12 back-to-back pixels, row 0 labelled 1..4.
        for (int i = 0; i < W * H; i++) send(ccl_label_t'(i + 1), f2[i], 1'b0);
        send(8'd9, 8'd30, 1'b0);
        send(8'd8, 8'd31, 1'b0);

        // Mid-frame reset directly after a pixel, pending label dropped.
        for (int i = 0; i < 5; i++) send(8'd1, ccl_label_t'(32 + i), 1'b0);
        mid_reset();
        for (int i = 0; i < 3; i++) send(8'd1, ccl_label_t'(40 + i), 1'b0);
        idle(2);

`ifdef CCL_FRAME_SYNC_EN
        mid_reset();
        for (int i = 0; i < 6; i++) send(8'd1, ccl_label_t'(50 + i), 1'b0);
        send(8'd1, 8'd60, 1'b1);
        for (int i = 0; i < W * H; i++) send(8'd1, ccl_label_t'(70 + i), 1'b0);
`endif

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        idle(2);
        chk("drain_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
